midi_encode: RTL and testbench

- Transmit-side counterpart to the MIDI receive path.
- Accepts note-on/note-off events (channel, note, velocity) through a valid/ready handshake.
- Serialises each event as a 3-byte MIDI message on a single-bit UART line at 31250 baud, 8N1, LSB first.
- Sits between the synth/sequencer logic and the MIDI OUT pin driver.

---
 rtl/midi_pkg.sv | 30 +++
 rtl/midi_encode_uart_transmit.sv | 67 ++++++
 rtl/midi_encode.sv | 151 +++++++++++++++
 tb/tb_midi_encode.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI transmit path: status nibbles, byte type,
// encoder FSM states and byte-formation helpers.
package midi_pkg;

    localparam int MIDI_BAUD = 31250;

    localparam logic [3:0] NOTE_ON_NIBBLE  = 4'h9;
    localparam logic [3:0] NOTE_OFF_NIBBLE = 4'h8;

    typedef logic [7:0] midi_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_STATUS = 3'd1,
        ST_SEND_NOTE   = 3'd2,
        ST_SEND_VEL    = 3'd3,
        ST_DONE        = 3'd4
    } midi_state_t;

    // Status byte: message-type nibble in the top half, channel in the bottom.
    function automatic midi_byte_t make_status(input logic note_on, input logic [3:0] channel);
        return {(note_on ? NOTE_ON_NIBBLE : NOTE_OFF_NIBBLE), channel};
    endfunction

    // MIDI data bytes always have bit 7 clear; the caller's bit 7 is discarded.
    function automatic midi_byte_t make_data(input logic [7:0] value);
        return {1'b0, value[6:0]};
    endfunction

endpackage

// File: rtl/midi_encode_uart_transmit.sv
// 8N1 byte serialiser, LSB first. A one-cycle trigger_in while idle loads a
// byte and drives the start bit on the next edge; busy_out falls at the edge
// the stop bit completes. The line output is a flop, so it never glitches.
module uart_transmit
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = MIDI_BAUD
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_byte_in,
    input  logic       trigger_in,
    output logic       busy_out,
    output logic       tx_wire_out
);

    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_BIT_PERIOD - 1);

    // bit_idx: 0 = start, 1..8 = data bits 0..7, 9 = stop
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             busy_q;
    logic             tx_q;

    // Baud counter, bit index and shift register; line updates on bit boundaries.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else if (!busy_q) begin
            if (trigger_in) begin
                busy_q   <= 1'b1;
                tx_q     <= 1'b0;
                shift_q  <= data_byte_in;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                // Stop bit has run its full period; the line is already high.
                busy_q <= 1'b0;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd8) begin
                    tx_q <= 1'b1;
                end else begin
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b0, shift_q[7:1]};
                end
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign busy_out    = busy_q;
    assign tx_wire_out = tx_q;

endmodule

// File: rtl/midi_encode.sv
// MIDI OUT message sequencer: accepts note-on/off events over valid/ready and
// sends status, note and velocity bytes through uart_transmit.
// Optional build macro MIDI_RUNNING_STATUS_EN: omit the status byte when it
// repeats the previously transmitted one.
//
// Handshake: an event transfers on a rising edge where valid_in && ready_out;
// ready_out is high only in IDLE, inputs are sampled only on that edge, and
// valid_in is ignored at all other times (upstream holds it until ready).
module midi_encode
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = MIDI_BAUD
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_in,
    input  logic       status_in,
    input  logic [3:0] channel_in,
    input  logic [7:0] note_in,
    input  logic [7:0] velocity_in,
    output logic       ready_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       midi_data_out
);

    midi_state_t state_q, state_d;
    logic        fired_q, fired_d;    // current SEND state has already triggered its byte
    midi_byte_t  status_q, note_q, vel_q;
    midi_byte_t  new_status;
    midi_byte_t  tx_byte;
    logic        trigger;
    logic        uart_busy;
    logic        accept;
    logic        skip_status;

    assign accept     = valid_in && ready_out;
    assign new_status = make_status(status_in, channel_in);

`ifdef MIDI_RUNNING_STATUS_EN
    midi_byte_t last_status_q;
    logic       status_sent;

    // Status bytes are always >= 0x80, so the cleared value never matches.
    assign skip_status = (new_status == last_status_q);
    assign status_sent = (state_q == ST_SEND_STATUS) && !fired_q;

    // Remember the most recently transmitted status byte.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_status_q <= '0;
        end else if (status_sent) begin
            last_status_q <= status_q;
        end
    end
`else
    assign skip_status = 1'b0;
`endif

    // State register and event fields captured at accept.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            fired_q  <= 1'b0;
            status_q <= '0;
            note_q   <= '0;
            vel_q    <= '0;
        end else begin
            state_q <= state_d;
            fired_q <= fired_d;
            if (accept) begin
                status_q <= new_status;
                note_q   <= make_data(note_in);
                vel_q    <= make_data(velocity_in);
            end
        end
    end

    // Next-state logic; the next byte is triggered in the same cycle the
    // previous one finishes, keeping the inter-byte gap to one cycle.
    always_comb begin
        state_d = state_q;
        fired_d = fired_q;
        trigger = 1'b0;
        tx_byte = status_q;
        unique case (state_q)
            ST_IDLE: begin
                fired_d = 1'b0;
                if (valid_in) begin
                    state_d = skip_status ? ST_SEND_NOTE : ST_SEND_STATUS;
                end
            end
            ST_SEND_STATUS: begin
                tx_byte = status_q;
                if (!fired_q) begin
                    trigger = 1'b1;
                    fired_d = 1'b1;
                end else if (!uart_busy) begin
                    state_d = ST_SEND_NOTE;
                    tx_byte = note_q;
                    trigger = 1'b1;
                end
            end
            ST_SEND_NOTE: begin
                tx_byte = note_q;
                if (!fired_q) begin
                    trigger = 1'b1;
                    fired_d = 1'b1;
                end else if (!uart_busy) begin
                    state_d = ST_SEND_VEL;
                    tx_byte = vel_q;
                    trigger = 1'b1;
                end
            end
            ST_SEND_VEL: begin
                tx_byte = vel_q;
                if (!fired_q) begin
                    trigger = 1'b1;
                    fired_d = 1'b1;
                end else if (!uart_busy) begin
                    state_d = ST_DONE;
                    fired_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready_out = (state_q == ST_IDLE);
    assign busy_out  = (state_q != ST_IDLE);
    assign done_out  = (state_q == ST_DONE);

    uart_transmit #(
        .INPUT_CLOCK_FREQ (INPUT_CLOCK_FREQ),
        .BAUD_RATE        (BAUD_RATE)
    ) u_uart (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_byte_in (tx_byte),
        .trigger_in   (trigger),
        .busy_out     (uart_busy),
        .tx_wire_out  (midi_data_out)
    );

endmodule

// File: tb/tb_midi_encode.sv
// Directed bench for midi_encode at 16 clocks per bit: decodes the serial line
// against an expected byte queue and checks handshake, framing, done pulse,
// reset abort and (when MIDI_RUNNING_STATUS_EN is defined) running status.
module tb_midi_encode;

    localparam int CLK_FREQ = 500_000;
    localparam int BAUD     = 31250;
    localparam int P        = CLK_FREQ / BAUD;   // 16 clocks per bit

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       valid_in = 1'b0;
    logic       status_in = 1'b0;
    logic [3:0] channel_in = 4'h0;
    logic [7:0] note_in = 8'h00;
    logic [7:0] velocity_in = 8'h00;
    logic       ready_out;
    logic       busy_out;
    logic       done_out;
    logic       midi_data_out;

    int assert_count = 0;
    int fail_count   = 0;
    int done_count   = 0;

    logic [7:0] exp_q[$];

    midi_encode #(
        .INPUT_CLOCK_FREQ (CLK_FREQ),
        .BAUD_RATE        (BAUD)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .status_in     (status_in),
        .channel_in    (channel_in),
        .note_in       (note_in),
        .velocity_in   (velocity_in),
        .ready_out     (ready_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .midi_data_out (midi_data_out)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Count done pulses on every active edge
    always @(posedge clk_in) begin
        if (done_out === 1'b1) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (cycles) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Driver: present an event, hold valid until accepted, then scramble inputs.
    task automatic send_event(input string tag, input logic st, input logic [3:0] ch,
                              input logic [7:0] note, input logic [7:0] vel,
                              output int waited);
        @(negedge clk_in);
        status_in   = st;
        channel_in  = ch;
        note_in     = note;
        velocity_in = vel;
        valid_in    = 1'b1;
        waited      = 0;
        while (ready_out !== 1'b1 && waited < 2000) begin
            @(negedge clk_in);
            waited++;
        end
        check({tag, "_ready"}, {31'b0, ready_out}, 32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in    = 1'b0;
        status_in   = 1'($urandom_range(0, 1));
        channel_in  = 4'($urandom_range(0, 15));
        note_in     = 8'($urandom_range(0, 255));
        velocity_in = 8'($urandom_range(0, 255));
        check({tag, "_busy_after_accept"}, {31'b0, busy_out}, 32'd1);
        check({tag, "_ready_after_accept"}, {31'b0, ready_out}, 32'd0);
        @(negedge clk_in);
        check({tag, "_start_latency"}, {31'b0, midi_data_out}, 32'd0);
    endtask

    // Receive one frame, checking every bit holds for P cycles.
    task automatic recv_byte(input string tag, input int max_wait);
        int         found;
        int         stable;
        logic [7:0] data;
        logic       stop_bit;
        logic       first;
        logic [31:0] e;
        found    = 0;
        stable   = 1;
        data     = 8'h00;
        stop_bit = 1'b0;
        for (int w = 0; w < max_wait && found == 0; w++) begin
            @(negedge clk_in);
            if (midi_data_out === 1'b0) found = 1;
        end
        check({tag, "_start_seen"}, found, 32'd1);
        if (found != 0) begin
            for (int c = 1; c < P; c++) begin
                @(negedge clk_in);
                if (midi_data_out !== 1'b0) stable = 0;
            end
            for (int b = 0; b < 9; b++) begin
                @(negedge clk_in);
                first = midi_data_out;
                for (int c = 1; c < P; c++) begin
                    @(negedge clk_in);
                    if (midi_data_out !== first) stable = 0;
                end
                if (b < 8) data[b] = first;
                else stop_bit = first;
            end
            if (exp_q.size() > 0) e = {24'h0, exp_q.pop_front()};
            else e = 'x;
            check({tag, "_bit_stable"}, stable, 32'd1);
            check({tag, "_stop"}, {31'b0, stop_bit}, 32'd1);
            check({tag, "_data"}, {24'h0, data}, e);
        end
    endtask

    // Receive a whole message and its single done pulse.
    task automatic recv_msg(input string tag, input int nbytes);
        int d0;
        int seen;
        d0   = done_count;
        seen = 0;
        recv_byte($sformatf("%s_b0", tag), 2000);
        for (int i = 1; i < nbytes; i++) recv_byte($sformatf("%s_b%0d", tag, i), 2);
        for (int w = 0; w < 3 && seen == 0; w++) begin
            @(negedge clk_in);
            if (done_out === 1'b1) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 32'd1);
        repeat (2) @(negedge clk_in);
        check({tag, "_done_pulses"}, done_count - d0, 32'd1);
    endtask

    // Directed sequence
    initial begin
        int w1;
        int w2;
        int d0;
        int high;

        // Reset: held three cycles
        reset_dut(3);
        check("rst_line", {31'b0, midi_data_out}, 32'd1);
        check("rst_ready", {31'b0, ready_out}, 32'd1);
        check("rst_busy", {31'b0, busy_out}, 32'd0);
        check("rst_done", {31'b0, done_out}, 32'd0);

        // Note on, channel 0
        exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
        fork
            send_event("non", 1'b1, 4'h0, 8'h3C, 8'h64, w1);
            recv_msg("non", 3);
        join
        check("non_ready_idle", {31'b0, ready_out}, 32'd1);

        // Note off with bit-7 masking
        exp_q.push_back(8'h8F); exp_q.push_back(8'h3C); exp_q.push_back(8'h7F);
        fork
            send_event("noff", 1'b0, 4'hF, 8'hBC, 8'hFF, w1);
            recv_msg("noff", 3);
        join

        // Backpressure: second event held valid while the first is in flight
        exp_q.push_back(8'h93); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        exp_q.push_back(8'h84); exp_q.push_back(8'h11); exp_q.push_back(8'h21);
        fork
            begin
                send_event("bp1", 1'b1, 4'h3, 8'h10, 8'h20, w1);
                send_event("bp2", 1'b0, 4'h4, 8'h11, 8'h21, w2);
                check("bp2_held_off", {31'b0, (w2 >= 30 * P)}, 32'd1);
            end
            begin
                recv_msg("bp1", 3);
                recv_msg("bp2", 3);
            end
        join
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Reset during data bit 3 of the note byte (0x45 has bit 3 low)
        exp_q.push_back(8'h95);
        fork
            send_event("rmm", 1'b1, 4'h5, 8'h45, 8'h20, w1);
            begin
                recv_byte("rmm_status", 2000);
                for (int w = 0; w < 2 && midi_data_out !== 1'b0; w++) @(negedge clk_in);
                repeat (4 * P + P / 2 - 1) @(negedge clk_in);
                check("rmm_bit3_low", {31'b0, midi_data_out}, 32'd0);
                rst_in = 1'b1;
                d0 = done_count;
                @(negedge clk_in);
                check("rmm_line_high", {31'b0, midi_data_out}, 32'd1);
                check("rmm_ready", {31'b0, ready_out}, 32'd1);
                check("rmm_busy", {31'b0, busy_out}, 32'd0);
                rst_in = 1'b0;
                high = 1;
                repeat (30 * P) begin
                    @(negedge clk_in);
                    if (midi_data_out !== 1'b1) high = 0;
                end
                check("rmm_line_stays_high", high, 32'd1);
                check("rmm_no_done", done_count - d0, 32'd0);
            end
        join

        // Full frame after the abort; velocity 0 stays a note-on
        exp_q.push_back(8'h92); exp_q.push_back(8'h7F); exp_q.push_back(8'h00);
        fork
            send_event("post", 1'b1, 4'h2, 8'h7F, 8'h00, w1);
            recv_msg("post", 3);
        join

        // Running status: 0x91, 0x91, 0x81
        exp_q.push_back(8'h91); exp_q.push_back(8'h40); exp_q.push_back(8'h50);
        fork
            send_event("rs1", 1'b1, 4'h1, 8'h40, 8'h50, w1);
            recv_msg("rs1", 3);
        join
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q.push_back(8'h41); exp_q.push_back(8'h51);
        fork
            send_event("rs2", 1'b1, 4'h1, 8'h41, 8'h51, w1);
            recv_msg("rs2", 2);
        join
`else
        exp_q.push_back(8'h91); exp_q.push_back(8'h41); exp_q.push_back(8'h51);
        fork
            send_event("rs2", 1'b1, 4'h1, 8'h41, 8'h51, w1);
            recv_msg("rs2", 3);
        join
`endif
        exp_q.push_back(8'h81); exp_q.push_back(8'h41); exp_q.push_back(8'h00);
        fork
            send_event("rs3", 1'b0, 4'h1, 8'h41, 8'h00, w1);
            recv_msg("rs3", 3);
        join
        check("final_queue_empty", exp_q.size(), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
